// File: rtl/spi_reg_bridge_if.sv
// Bundle of SPI pins and register-bank bus signals for spi_reg_bridge.
// The bridge uses the slave modport; the host/register-bank side uses master.
interface spi_reg_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  spi_sck;
    logic                  spi_ss;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  reg_en;
    logic                  reg_rd;
    logic                  reg_wr;
    logic [1:0]            reg_be;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  busy;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, reg_rdata,
        output spi_miso, reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_wdata, busy
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, reg_rdata,
        input  spi_miso, reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_wdata, busy
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit command/data frames into register-bank
// read and write cycles with auto-incrementing addresses.
module spi_reg_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CMD, RD_ACCESS, DATA, WR_SETUP, WR_STROBE, WR_HOLD
    } state_t;

    // Synchronizer idle levels, ordered {sck, ss, mosi}
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    logic [2:0]            meta_reg, sync_reg;
    logic                  sck_d_reg, ss_d_reg;
    logic                  sck_s, ss_s, mosi_s;
    logic                  sck_rise, sck_fall, ss_fall, word_done;

    state_t                state_reg, state_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] sr_reg, sr_next, sr_shift;
    logic                  is_wr_reg, is_wr_next;
    logic                  rd_cnt_reg, rd_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [1:0]            be_reg, be_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  en_reg, en_next;
    logic                  rd_n_reg, rd_n_next;
    logic                  wr_n_reg, wr_n_next;
    logic                  busy_reg, busy_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg  <= SYNC_IDLE;
            sync_reg  <= SYNC_IDLE;
            sck_d_reg <= 1'b0;
            ss_d_reg  <= 1'b1;
        end else begin
            meta_reg  <= {bus.spi_sck, bus.spi_ss, bus.spi_mosi};
            sync_reg  <= meta_reg;
            sck_d_reg <= sync_reg[2];
            ss_d_reg  <= sync_reg[1];
        end
    end

    assign sck_s     = sync_reg[2];
    assign ss_s      = sync_reg[1];
    assign mosi_s    = sync_reg[0];
    assign sck_rise  = sck_s & ~sck_d_reg;
    assign sck_fall  = ~sck_s & sck_d_reg;
    assign ss_fall   = ss_d_reg & ~ss_s;
    assign word_done = sck_rise && (bit_cnt_reg == 4'd15);
    assign sr_shift  = {sr_reg[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            sr_reg      <= '0;
            is_wr_reg   <= 1'b0;
            rd_cnt_reg  <= 1'b0;
            addr_reg    <= '0;
            be_reg      <= '0;
            wdata_reg   <= '0;
            en_reg      <= 1'b0;
            rd_n_reg    <= 1'b1;
            wr_n_reg    <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            sr_reg      <= sr_next;
            is_wr_reg   <= is_wr_next;
            rd_cnt_reg  <= rd_cnt_next;
            addr_reg    <= addr_next;
            be_reg      <= be_next;
            wdata_reg   <= wdata_next;
            en_reg      <= en_next;
            rd_n_reg    <= rd_n_next;
            wr_n_reg    <= wr_n_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        sr_next      = sr_reg;
        is_wr_next   = is_wr_reg;
        rd_cnt_next  = rd_cnt_reg;
        addr_next    = addr_reg;
        be_next      = be_reg;
        wdata_next   = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next   = CMD;
                    bit_cnt_next = '0;
                    sr_next      = '0;
                end
            end
            CMD: begin
                if (ss_s) begin
                    state_next = IDLE;
                end else if (sck_rise) begin
                    sr_next      = sr_shift;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (word_done) begin
                        is_wr_next  = sr_shift[15];
                        be_next     = sr_shift[14:13];
                        addr_next   = sr_shift[ADDR_WIDTH-1:0];
                        rd_cnt_next = 1'b0;
                        state_next  = sr_shift[15] ? DATA : RD_ACCESS;
                    end
                end
            end
            RD_ACCESS: begin
                rd_cnt_next = 1'b1;
                if (rd_cnt_reg) begin
                    sr_next    = bus.reg_rdata;
                    state_next = ss_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (ss_s) begin
                    state_next = IDLE;
                end else if (is_wr_reg) begin
                    if (sck_rise) begin
                        sr_next      = sr_shift;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (word_done) begin
                            wdata_next = sr_shift;
                            state_next = WR_SETUP;
                        end
                    end
                end else if (sck_rise) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (word_done) begin
                        addr_next   = addr_reg + ADDR_WIDTH'(1);
                        rd_cnt_next = 1'b0;
                        state_next  = RD_ACCESS;
                    end
                // The falling edge that closes a word must not shift out the
                // freshly loaded MSB, so only shift once a bit has been clocked.
                end else if (sck_fall && bit_cnt_reg != 4'd0) begin
                    sr_next = {sr_reg[DATA_WIDTH-2:0], 1'b0};
                end
            end
            WR_SETUP:  state_next = WR_STROBE;
            WR_STROBE: state_next = WR_HOLD;
            WR_HOLD: begin
                addr_next  = addr_reg + ADDR_WIDTH'(1);
                state_next = ss_s ? IDLE : DATA;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state and registered so they are
    // glitch-free and line up exactly with the state they belong to.
    always_comb begin
        en_next   = (state_next == RD_ACCESS) || (state_next == WR_SETUP) ||
                    (state_next == WR_STROBE) || (state_next == WR_HOLD);
        rd_n_next = (state_next != RD_ACCESS);
        wr_n_next = (state_next != WR_STROBE);
        busy_next = (state_next != IDLE);
    end

    assign bus.spi_miso  = (state_reg == DATA) && !is_wr_reg && !bus.spi_ss && sr_reg[DATA_WIDTH-1];
    assign bus.reg_en    = en_reg;
    assign bus.reg_rd    = rd_n_reg;
    assign bus.reg_wr    = wr_n_reg;
    assign bus.reg_be    = be_reg;
    assign bus.reg_addr  = addr_reg;
    assign bus.reg_wdata = wdata_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning register address bus width (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning register data bus width (fixed at 16).
REQ-003 clk  input  1  system clock; SHALL run at least 8x spi_sck frequency.
REQ-004 reset  input  1  asynchronous, active-low system reset.
REQ-005 spi_sck  input  1  host SPI clock, mode 0, asynchronous to clk.
REQ-006 spi_ss  input  1  active-low slave select.
REQ-007 spi_mosi  input  1  host-to-block serial data, MSB first.
REQ-008 spi_miso  output  1  block-to-host serial data, MSB first.
REQ-009 reg_en  output  1  register bus access enable.
REQ-010 reg_rd  output  1  active-low read strobe.
REQ-011 reg_wr  output  1  active-low write strobe; registers capture on its falling edge.
REQ-012 reg_be  output  2  byte enables [1]=high byte, [0]=low byte.
REQ-013 reg_addr  output  ADDR_WIDTH  register address.
REQ-014 reg_wdata  output  DATA_WIDTH  write data, to register bank data input.
REQ-015 reg_rdata  input  DATA_WIDTH  read data, from register bank data output.
REQ-016 busy  output  1  high while a frame or bus access is in progress.

Function
REQ-017 spi_sck, spi_ss, spi_mosi SHALL pass through 2-flop synchronizers; sck rising/falling edges detected from synchronized samples.
REQ-018 Frame = spi_ss low; first 16 bits = command: [15]=1 write/0 read, [14:13]=byte enables, [12:8] ignored, [7:0]=start address (low ADDR_WIDTH bits used).
REQ-019 Each subsequent 16-bit word SHALL be one data word; address SHALL increment by 1 after each word, wrapping modulo 2^ADDR_WIDTH.
REQ-020 States: IDLE, CMD, RD_ACCESS, DATA, WR_SETUP, WR_STROBE, WR_HOLD.
REQ-021 IDLE -> CMD on synchronized spi_ss falling; bit counter cleared.
REQ-022 CMD: shift mosi on each sck rising; after 16th bit -> RD_ACCESS if read, else DATA.
REQ-023 RD_ACCESS: 2 cycles with reg_en=1, reg_rd=0; reg_rdata captured into shift register at end of 2nd cycle; -> DATA.
REQ-024 Read DATA: spi_miso SHALL present shift-register MSB; shift on sck falling; after 16th rising edge, address increments -> RD_ACCESS.
REQ-025 Write DATA: shift mosi on sck rising; after 16th bit latch reg_wdata -> WR_SETUP.
REQ-026 WR_SETUP (1 cycle): reg_en=1, reg_wr=1, addr/be/wdata stable; WR_STROBE (1 cycle): reg_wr=0; WR_HOLD (1 cycle): reg_wr=1, reg_en=1; then address increments -> DATA.
REQ-027 reg_addr, reg_be, reg_wdata SHALL remain stable from WR_SETUP through WR_HOLD.
REQ-028 Outside RD_ACCESS/WR_*: reg_en=0, reg_rd=1, reg_wr=1.
REQ-029 reg_rd and reg_wr SHALL never be low simultaneously.
REQ-030 spi_ss rising in CMD/DATA SHALL abort to IDLE; partial words discarded, no bus write issued.
REQ-031 spi_ss rising during WR_SETUP/WR_STROBE/WR_HOLD SHALL let the write sequence complete, then -> IDLE.
REQ-032 spi_miso SHALL be 0 when spi_ss is high or in CMD.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 On reset low, asynchronously: state=IDLE, reg_en=0, reg_rd=1, reg_wr=1, reg_be=0, reg_addr=0, reg_wdata=0, spi_miso=0, busy=0, counters and shift registers 0, synchronizer flops to idle levels (sck=0, ss=1, mosi=0).
REQ-035 Reset asserted mid-frame or mid-strobe SHALL abort immediately; no further strobes until a new frame starts after reset release.

Verification
REQ-036 Write: cmd 0xE005, data 0x1234 -> one reg_wr low pulse, reg_addr=0x05, reg_be=2'b11, reg_wdata=0x1234.
REQ-037 Read: cmd 0x6010, reg_rdata=0xBEEF at addr 0x10 -> reg_rd low 2 cycles, miso shifts 0xBEEF.
REQ-038 Burst write: cmd 0xA0FF, words 0x0001, 0x0002 -> writes to addr 0xFF then 0x00 (wrap), reg_be=2'b01.
REQ-039 Abort: ss high after 10 data bits of write -> no reg_wr pulse, busy=0 within 4 cycles.
REQ-040 ss high one cycle into WR_STROBE -> strobe completes, exactly one write, then IDLE.
REQ-041 Reset low during WR_STROBE -> reg_wr=1, reg_en=0 immediately, all outputs at reset values.
